// File: rtl/of_hazard_ctrl_if.sv
// rtl/of_hazard_ctrl_if.sv - OF-stage hazard controller signal bundle
interface of_hazard_ctrl_if #(
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4,
    parameter int CNT_W    = 16
) ();
    logic                Start;
    logic                Of_Valid;
    logic [REG_AW-1:0]   Of_Rs1;
    logic                Of_Rs1_En;
    logic [REG_AW-1:0]   Of_Rs2;
    logic                Of_Rs2_En;
    logic [REG_AW-1:0]   Of_Rd;
    logic                Of_Wb_En;
    logic                Of_MulDiv;
    logic                Wb_Valid;
    logic [REG_AW-1:0]   Wb_Rd;
    logic                Ex_Br_Taken;
    logic                Stall;
    logic                If_Flush;
    logic                Of_Ex_Flush;
    logic                Issue;
    logic                Md_Busy;
    logic [NUM_REGS-1:0] Sb_Busy;
    logic                Sb_Err;
    logic [CNT_W-1:0]    Stall_Cnt;

    modport master (
        output Start, Of_Valid, Of_Rs1, Of_Rs1_En, Of_Rs2, Of_Rs2_En, Of_Rd, Of_Wb_En,
               Of_MulDiv, Wb_Valid, Wb_Rd, Ex_Br_Taken,
        input  Stall, If_Flush, Of_Ex_Flush, Issue, Md_Busy, Sb_Busy, Sb_Err, Stall_Cnt
    );

    modport slave (
        input  Start, Of_Valid, Of_Rs1, Of_Rs1_En, Of_Rs2, Of_Rs2_En, Of_Rd, Of_Wb_En,
               Of_MulDiv, Wb_Valid, Wb_Rd, Ex_Br_Taken,
        output Stall, If_Flush, Of_Ex_Flush, Issue, Md_Busy, Sb_Busy, Sb_Err, Stall_Cnt
    );
endinterface

// File: rtl/of_hazard_ctrl.sv
// rtl/of_hazard_ctrl.sv - scoreboard interlock and flush control for the OF stage
module of_hazard_ctrl #(
    parameter int NUM_REGS   = 16,
    parameter int REG_AW     = 4,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    of_hazard_ctrl_if.slave  bus
);
    localparam int MD_W = $clog2(MULDIV_LAT) + 1;

    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [MD_W-1:0]     md_cnt_q, md_cnt_d;
    logic                sb_err_q, sb_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] sb_set;
    logic [NUM_REGS-1:0] avail;
    logic                raw, waw, md_busy, stall, issue, wb_orphan;

    always_comb begin
        wb_clr = '0;
        sb_set = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wb_clr[i] = bus.Wb_Valid && (bus.Wb_Rd == REG_AW'(i));
        end
        // Write-through RF: a register retiring this cycle is already readable.
        avail   = ~sb_q | wb_clr;
        raw     = (bus.Of_Rs1_En && !avail[bus.Of_Rs1]) || (bus.Of_Rs2_En && !avail[bus.Of_Rs2]);
        waw     = bus.Of_Wb_En && !avail[bus.Of_Rd];
        md_busy = (md_cnt_q != '0);

        // Rst gating keeps every comb output low while reset is asserted.
        stall = Rst && bus.Of_Valid && !bus.Ex_Br_Taken && (raw || waw || md_busy);
        issue = Rst && bus.Start && bus.Of_Valid && !stall && !bus.Ex_Br_Taken;

        for (int i = 0; i < NUM_REGS; i++) begin
            sb_set[i] = issue && bus.Of_Wb_En && (bus.Of_Rd == REG_AW'(i));
        end
        sb_d = (sb_q & ~wb_clr) | sb_set;

        wb_orphan = bus.Wb_Valid && !sb_q[bus.Wb_Rd] && !sb_set[bus.Wb_Rd];
        sb_err_d  = sb_err_q || wb_orphan;

        if (issue && bus.Of_MulDiv) begin
            md_cnt_d = MD_W'(MULDIV_LAT - 1);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end else begin
            md_cnt_d = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sb_q        <= '0;
            md_cnt_q    <= '0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            md_cnt_q    <= md_cnt_d;
            sb_err_q    <= sb_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Stall       = stall;
    assign bus.Issue       = issue;
    assign bus.If_Flush    = Rst && bus.Ex_Br_Taken;
    assign bus.Of_Ex_Flush = Rst && (bus.Ex_Br_Taken || stall);
    assign bus.Md_Busy     = md_busy;
    assign bus.Sb_Busy     = sb_q;
    assign bus.Sb_Err      = sb_err_q;
    assign bus.Stall_Cnt   = stall_cnt_q;
endmodule

// File: tb/tb_of_hazard_ctrl.sv
// tb/tb_of_hazard_ctrl.sv - directed self-checking bench for of_hazard_ctrl
module tb_of_hazard_ctrl;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    of_hazard_ctrl_if #(.NUM_REGS(16), .REG_AW(4), .CNT_W(16)) bus ();

    of_hazard_ctrl #(.NUM_REGS(16), .REG_AW(4), .MULDIV_LAT(4), .CNT_W(16)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Rst && bus.Ex_Br_Taken && bus.Md_Busy) begin
            mismatched++;
            $display("FAIL br_during_md: Ex_Br_Taken=1 while Md_Busy=1, required never");
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.Start = 1'b1; bus.Of_Valid = 1'b0;
        bus.Of_Rs1 = '0; bus.Of_Rs1_En = 1'b0; bus.Of_Rs2 = '0; bus.Of_Rs2_En = 1'b0;
        bus.Of_Rd = '0; bus.Of_Wb_En = 1'b0; bus.Of_MulDiv = 1'b0;
        bus.Wb_Valid = 1'b0; bus.Wb_Rd = '0; bus.Ex_Br_Taken = 1'b0;
    endtask

    task automatic op(input logic [3:0] rs1, input logic rs1_en, input logic [3:0] rd,
                      input logic wb_en, input logic md);
        bus.Of_Valid = 1'b1; bus.Of_Rs1 = rs1; bus.Of_Rs1_En = rs1_en;
        bus.Of_Rs2 = '0; bus.Of_Rs2_En = 1'b0;
        bus.Of_Rd = rd; bus.Of_Wb_En = wb_en; bus.Of_MulDiv = md;
    endtask

    task automatic test_reset();
        idle();
        Rst = 1'b0;
        bus.Of_Valid = 1'b1; bus.Ex_Br_Taken = 1'b1;
        #3;
        compared++; if (bus.Sb_Busy !== 16'h0000) begin mismatched++; $display("FAIL rst_sb: got %h want 0000", bus.Sb_Busy); end
        compared++; if (bus.Issue !== 1'b0) begin mismatched++; $display("FAIL rst_issue: got %b want 0", bus.Issue); end
        compared++; if (bus.If_Flush !== 1'b0 || bus.Of_Ex_Flush !== 1'b0) begin mismatched++; $display("FAIL rst_flush: got %b%b want 00", bus.If_Flush, bus.Of_Ex_Flush); end
        compared++; if (bus.Md_Busy !== 1'b0 || bus.Sb_Err !== 1'b0 || bus.Stall_Cnt !== 16'd0) begin mismatched++; $display("FAIL rst_state: md=%b err=%b cnt=%0d want 0 0 0", bus.Md_Busy, bus.Sb_Err, bus.Stall_Cnt); end
        cyc();
        idle();
        Rst = 1'b1;
        cyc();
    endtask

    task automatic test_raw();
        op(4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        #1;
        compared++; if (bus.Issue !== 1'b1) begin mismatched++; $display("FAIL raw_issue0: got %b want 1", bus.Issue); end
        cyc();
        compared++; if (bus.Sb_Busy !== 16'h0008) begin mismatched++; $display("FAIL raw_sb_set: got %h want 0008", bus.Sb_Busy); end
        op(4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            compared++; if (bus.Stall !== 1'b1 || bus.Issue !== 1'b0 || bus.Of_Ex_Flush !== 1'b1) begin mismatched++; $display("FAIL raw_stall: stall=%b issue=%b flush=%b want 1 0 1", bus.Stall, bus.Issue, bus.Of_Ex_Flush); end
            cyc();
        end
        bus.Wb_Valid = 1'b1; bus.Wb_Rd = 4'd3;
        #1;
        compared++; if (bus.Stall !== 1'b0 || bus.Issue !== 1'b1) begin mismatched++; $display("FAIL raw_release: stall=%b issue=%b want 0 1", bus.Stall, bus.Issue); end
        cyc();
        compared++; if (bus.Sb_Busy !== 16'h0000) begin mismatched++; $display("FAIL raw_sb_clr: got %h want 0000", bus.Sb_Busy); end
        compared++; if (bus.Stall_Cnt !== 16'd2) begin mismatched++; $display("FAIL raw_cnt: got %0d want 2", bus.Stall_Cnt); end
        idle();
    endtask

    task automatic test_muldiv();
        op(4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        compared++; if (bus.Issue !== 1'b1) begin mismatched++; $display("FAIL md_issue: got %b want 1", bus.Issue); end
        cyc();
        op(4'd1, 1'b1, 4'd6, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            compared++; if (bus.Md_Busy !== 1'b1 || bus.Stall !== 1'b1) begin mismatched++; $display("FAIL md_busy_t%0d: md=%b stall=%b want 1 1", i, bus.Md_Busy, bus.Stall); end
            cyc();
        end
        #1;
        compared++; if (bus.Md_Busy !== 1'b0 || bus.Stall !== 1'b0 || bus.Issue !== 1'b1) begin mismatched++; $display("FAIL md_t4: md=%b stall=%b issue=%b want 0 0 1", bus.Md_Busy, bus.Stall, bus.Issue); end
        cyc();
        compared++; if (bus.Sb_Busy !== 16'h0040 || bus.Stall_Cnt !== 16'd5) begin mismatched++; $display("FAIL md_after: sb=%h cnt=%0d want 0040 5", bus.Sb_Busy, bus.Stall_Cnt); end
        idle();
        bus.Wb_Valid = 1'b1; bus.Wb_Rd = 4'd6;
        cyc();
        idle();
    endtask

    task automatic test_branch();
        op(4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        cyc();
        op(4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        bus.Of_Rs2 = 4'd5; bus.Of_Rs2_En = 1'b1;
        #1;
        compared++; if (bus.Stall !== 1'b1) begin mismatched++; $display("FAIL br_pre_stall: got %b want 1", bus.Stall); end
        cyc();
        bus.Ex_Br_Taken = 1'b1;
        #1;
        compared++; if (bus.If_Flush !== 1'b1 || bus.Of_Ex_Flush !== 1'b1 || bus.Stall !== 1'b0 || bus.Issue !== 1'b0) begin mismatched++; $display("FAIL br_flush: iff=%b oef=%b stall=%b issue=%b want 1 1 0 0", bus.If_Flush, bus.Of_Ex_Flush, bus.Stall, bus.Issue); end
        cyc();
        compared++; if (bus.Sb_Busy !== 16'h0020 || bus.Stall_Cnt !== 16'd6) begin mismatched++; $display("FAIL br_after: sb=%h cnt=%0d want 0020 6", bus.Sb_Busy, bus.Stall_Cnt); end
        idle();
    endtask

    task automatic test_collision();
        op(4'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        bus.Wb_Valid = 1'b1; bus.Wb_Rd = 4'd5;
        #1;
        compared++; if (bus.Issue !== 1'b1 || bus.Stall !== 1'b0) begin mismatched++; $display("FAIL col_issue: issue=%b stall=%b want 1 0", bus.Issue, bus.Stall); end
        cyc();
        compared++; if (bus.Sb_Busy !== 16'h0020 || bus.Sb_Err !== 1'b0) begin mismatched++; $display("FAIL col_sb: sb=%h err=%b want 0020 0", bus.Sb_Busy, bus.Sb_Err); end
        idle();
        bus.Wb_Valid = 1'b1; bus.Wb_Rd = 4'd5;
        cyc();
        idle();
        compared++; if (bus.Sb_Busy !== 16'h0000) begin mismatched++; $display("FAIL col_clr: got %h want 0000", bus.Sb_Busy); end
    endtask

    task automatic test_back_to_back();
        op(4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        cyc();
        op(4'd2, 1'b1, 4'd2, 1'b1, 1'b0);
        #1;
        compared++; if (bus.Issue !== 1'b1) begin mismatched++; $display("FAIL b2b_issue: got %b want 1", bus.Issue); end
        cyc();
        compared++; if (bus.Sb_Busy !== 16'h0006) begin mismatched++; $display("FAIL b2b_sb: got %h want 0006", bus.Sb_Busy); end
        op(4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
        #1;
        compared++; if (bus.Stall !== 1'b1) begin mismatched++; $display("FAIL b2b_waw: got %b want 1", bus.Stall); end
        cyc();
        bus.Wb_Valid = 1'b1; bus.Wb_Rd = 4'd1;
        #1;
        compared++; if (bus.Issue !== 1'b1) begin mismatched++; $display("FAIL b2b_waw_rel: got %b want 1", bus.Issue); end
        cyc();
        compared++; if (bus.Sb_Busy !== 16'h0006 || bus.Stall_Cnt !== 16'd7) begin mismatched++; $display("FAIL b2b_after: sb=%h cnt=%0d want 0006 7", bus.Sb_Busy, bus.Stall_Cnt); end
        idle();
        bus.Start = 1'b0; bus.Of_Valid = 1'b1;
        bus.Wb_Valid = 1'b1; bus.Wb_Rd = 4'd1;
        #1;
        compared++; if (bus.Issue !== 1'b0 || bus.Stall !== 1'b0) begin mismatched++; $display("FAIL start_low: issue=%b stall=%b want 0 0", bus.Issue, bus.Stall); end
        cyc();
        bus.Wb_Rd = 4'd2;
        cyc();
        idle();
        compared++; if (bus.Sb_Busy !== 16'h0000) begin mismatched++; $display("FAIL start_low_clr: got %h want 0000", bus.Sb_Busy); end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 8; r++) begin
            op(4'd0, 1'b0, 4'(r), 1'b1, 1'b0);
            cyc();
        end
        op(4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc();
        op(4'd0, 1'b1, 4'd9, 1'b1, 1'b0);
        #1;
        compared++; if (bus.Sb_Busy !== 16'h00FF || bus.Md_Busy !== 1'b1 || bus.Stall !== 1'b1) begin mismatched++; $display("FAIL rmid_pre: sb=%h md=%b stall=%b want 00ff 1 1", bus.Sb_Busy, bus.Md_Busy, bus.Stall); end
        Rst = 1'b0;
        #1;
        compared++; if (bus.Sb_Busy !== 16'h0000 || bus.Md_Busy !== 1'b0 || bus.Stall !== 1'b0) begin mismatched++; $display("FAIL rmid_post: sb=%h md=%b stall=%b want 0000 0 0", bus.Sb_Busy, bus.Md_Busy, bus.Stall); end
        compared++; if (bus.Stall_Cnt !== 16'd0) begin mismatched++; $display("FAIL rmid_cnt: got %0d want 0", bus.Stall_Cnt); end
        idle();
        cyc();
        Rst = 1'b1;
        cyc();
    endtask

    task automatic test_error_sat();
        bus.Wb_Valid = 1'b1; bus.Wb_Rd = 4'd7;
        cyc();
        idle();
        compared++; if (bus.Sb_Err !== 1'b1) begin mismatched++; $display("FAIL err_set: got %b want 1", bus.Sb_Err); end
        cyc(); cyc();
        compared++; if (bus.Sb_Err !== 1'b1) begin mismatched++; $display("FAIL err_sticky: got %b want 1", bus.Sb_Err); end
        op(4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        cyc();
        op(4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            @(posedge Clk);
        end
        #1;
        compared++; if (bus.Stall_Cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat: got %h want ffff", bus.Stall_Cnt); end
        cyc();
        compared++; if (bus.Stall_Cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_hold: got %h want ffff", bus.Stall_Cnt); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_muldiv();
        test_branch();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_error_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
